// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Definitions shared by the fetch stage and the control/decode unit:
//   - fetch_state_e : fetch FSM states (FETCH / HOLD / FAULT)
//   - NOP_INSTR     : canonical no-op word (addi x0,x0,0)
//   - INSTR_BYTES   : instruction length in bytes, the sequential PC step
//   - OPCODE_*      : position and width of the opcode field in a word
//   - is_aligned()  : true when an address is on an instruction boundary
// ---------------------------------------------------------------------------
package rv_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
// Bundles both buses of the fetch stage:
//   instruction memory : imem_req, imem_addr -> ; <- imem_ack, imem_rdata
//   decode stage       : instr_valid, instr, instr_pc, opcode -> ;
//                        <- instr_ready, branch_taken, branch_target
// modport master : the fetch unit's view
// modport slave  : the view of the memory/decode environment
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
  import rv_pkg::*;

  logic                imem_req;
  logic [31:0]         imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  logic                instr_valid;
  logic                instr_ready;
  logic [31:0]         instr;
  logic [31:0]         instr_pc;
  logic [OPCODE_W-1:0] opcode;
  logic                branch_taken;
  logic [31:0]         branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

endinterface

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection for the fetch stage.
//   i_pc            : current program counter
//   i_branch_taken  : redirect request from decode
//   i_branch_target : redirect address
//   o_next_pc       : PC+4 (wrapping), the target, or the unchanged PC when
//                     the target is misaligned
//   o_misaligned    : redirect requested to a non word-aligned target
// ---------------------------------------------------------------------------
module pc_next
  import rv_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    o_next_pc    = i_pc + 32'(INSTR_BYTES);
    o_misaligned = 1'b0;
    if (i_branch_taken) begin
      if (is_aligned(i_branch_target)) begin
        o_next_pc = i_branch_target;
      end else begin
        // The PC stays put so the faulting redirect is not half-applied.
        o_next_pc    = i_pc;
        o_misaligned = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch stage: holds the PC, issues one instruction-memory
// request at a time, captures the returned word and offers it to decode
// under a valid/ready handshake, then steps the PC or redirects it.
//
// Parameters
//   RESET_PC  : PC after reset (must be 4-byte aligned)
//   NOP_INSTR : instruction register contents when nothing valid is held
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   fetch_bus     : memory + decode buses (ifetch_unit_if.master)
//   fetch_fault   : sticky, set by a redirect to a misaligned target
//   retired_count : number of completed decode handshakes (wraps)
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master fetch_bus,
  output logic          fetch_fault,
  output logic [31:0]   retired_count
);
  import rv_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_retired_count;
  logic        r_fetch_fault;

  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_capture;
  logic        w_handshake;

  pc_next u_pc_next (
    .i_pc            (r_pc),
    .i_branch_taken  (fetch_bus.branch_taken),
    .i_branch_target (fetch_bus.branch_target),
    .o_next_pc       (w_next_pc),
    .o_misaligned    (w_misaligned)
  );

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and state-decoded outputs. imem_req and instr_valid depend
  // on r_state alone, so no input reaches them combinationally.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next          = r_state;
    w_capture             = 1'b0;
    w_handshake           = 1'b0;
    fetch_bus.imem_req    = 1'b0;
    fetch_bus.instr_valid = 1'b0;

    unique case (r_state)
      ST_FETCH: begin
        fetch_bus.imem_req = 1'b1;
        if (fetch_bus.imem_ack) begin
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        fetch_bus.instr_valid = 1'b1;
        if (fetch_bus.instr_ready) begin
          w_handshake  = 1'b1;
          w_state_next = w_misaligned ? ST_FAULT : ST_FETCH;
        end
      end
      ST_FAULT: begin
        // Terminal until reset: no requests, nothing offered to decode.
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // PC, instruction register, fault flag and retire counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC;
      r_instr         <= NOP_INSTR;
      r_instr_pc      <= RESET_PC;
      r_fetch_fault   <= 1'b0;
      r_retired_count <= '0;
    end else begin
      if (w_capture) begin
        r_instr    <= fetch_bus.imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_handshake) begin
        // Drop the consumed word so opcode never shows a stale decode
        // while the next fetch is outstanding or after a fault.
        r_instr         <= NOP_INSTR;
        r_retired_count <= r_retired_count + 32'd1;
        r_pc            <= w_next_pc;
        if (w_misaligned) begin
          r_fetch_fault <= 1'b1;
        end
      end
    end
  end

  assign fetch_bus.imem_addr = r_pc;
  assign fetch_bus.instr     = r_instr;
  assign fetch_bus.instr_pc  = r_instr_pc;
  assign fetch_bus.opcode    = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign fetch_fault         = r_fetch_fault;
  assign retired_count       = r_retired_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Self-checking bench for ifetch_unit. A memory responder with configurable
// or random latency serves fetches from a fixed address->word function, the
// decode side is driven by directed sequences and a random phase, and a
// transaction-level model predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_fault;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_bus     (bus.master),
    .fetch_fault   (fetch_fault),
    .retired_count (retired_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: the reset vector holds addi x1,x0,5, others a scramble.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------------------------------------------------------------
  // Memory responder: acks a pending request after the configured number
  // of wait cycles; optionally throws stray acks while no request is up.
  // ---------------------------------------------------------------------
  int lat_cfg   = 0;
  bit rand_lat  = 1'b0;
  bit stray_ack = 1'b0;
  int wait_cnt  = 0;
  int lat_cur   = 0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      wait_cnt      = 0;
      bus.imem_ack  = 1'b0;
      bus.imem_rdata = 32'h0;
    end else if (bus.imem_req) begin
      if (wait_cnt >= (rand_lat ? lat_cur : lat_cfg)) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        wait_cnt       = 0;
        lat_cur        = $urandom_range(0, 3);
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      bus.imem_ack   = stray_ack & ($urandom_range(0, 1) == 1);
      bus.imem_rdata = $urandom;
    end
  end

  // ---------------------------------------------------------------------
  // Reference model: tracks whether a word is held, whether the unit has
  // faulted, and the PC / held word / retire count as plain values.
  // ---------------------------------------------------------------------
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_instr   = NOP_INSTR;
  logic [31:0] m_ipc     = RESET_PC;
  logic [31:0] m_count   = 32'h0;
  bit          m_holding = 1'b0;
  bit          m_faulted = 1'b0;
  int          m_seq     = 0;
  int          preload_seq = 0;
  logic [31:0] preload_val = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc      <= RESET_PC;
      m_instr   <= NOP_INSTR;
      m_ipc     <= RESET_PC;
      m_count   <= 32'h0;
      m_holding <= 1'b0;
      m_faulted <= 1'b0;
    end else begin
      if (preload_seq != m_seq) begin
        m_seq   <= preload_seq;
        m_count <= preload_val;
      end
      if (!m_faulted) begin
        if (!m_holding) begin
          if (bus.imem_ack) begin
            m_holding <= 1'b1;
            m_instr   <= bus.imem_rdata;
            m_ipc     <= m_pc;
          end
        end else if (bus.instr_ready) begin
          m_count   <= m_count + 32'd1;
          m_holding <= 1'b0;
          m_instr   <= NOP_INSTR;
          if (!bus.branch_taken)             m_pc <= m_pc + 32'd4;
          else if (bus.branch_target % 4 == 0) m_pc <= bus.branch_target;
          else                               m_faulted <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cyc_imem_req",    32'(bus.imem_req),    32'(!m_holding && !m_faulted));
    check("cyc_imem_addr",   bus.imem_addr,        m_pc);
    check("cyc_instr_valid", 32'(bus.instr_valid), 32'(m_holding));
    check("cyc_instr",       bus.instr,            m_instr);
    check("cyc_instr_pc",    bus.instr_pc,         m_ipc);
    check("cyc_opcode",      32'(bus.opcode),      32'(m_instr[6:0]));
    check("cyc_fetch_fault", 32'(fetch_fault),     32'(m_faulted));
    check("cyc_retired",     retired_count,        m_count);
    if (bus.instr_valid)
      check("cyc_instr_vs_mem", bus.instr, mem_word(bus.instr_pc));
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(bus.instr_valid), 32'd1);
  endtask

  // Counts consecutive request cycles, checking the address never moves.
  task automatic count_fetch(output int n);
    logic [31:0] first_addr;
    first_addr = bus.imem_addr;
    n = 0;
    while (bus.imem_req && n < 30) begin
      check("addr_stable", bus.imem_addr, first_addr);
      n++;
      tick();
    end
  endtask

  logic [31:0] saved_instr;
  int          n_fetch;

  initial begin
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;

    // ---- Reset values
    repeat (3) tick();
    check("rst_imem_addr",   bus.imem_addr,        RESET_PC);
    check("rst_instr",       bus.instr,            32'h0000_0013);
    check("rst_instr_pc",    bus.instr_pc,         RESET_PC);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_fetch_fault", 32'(fetch_fault),     32'd0);
    check("rst_retired",     retired_count,        32'd0);

    // ---- Zero-wait first fetch
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("first_req",  32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr,     32'h0000_0100);
    tick();
    check("first_valid",  32'(bus.instr_valid), 32'd1);
    check("first_opcode", 32'(bus.opcode),      32'h13);
    check("first_pc",     bus.instr_pc,         32'h0000_0100);
    check("first_instr",  bus.instr,            32'h0050_0093);

    // ---- 3-cycle latency, decode always ready
    lat_cfg = 3;
    bus.instr_ready = 1'b1;
    tick();
    check("lat_addr_104", bus.imem_addr, 32'h0000_0104);
    count_fetch(n_fetch);
    check("lat_cycles_104", 32'(n_fetch), 32'd4);
    check("lat_pc_104",     bus.instr_pc, 32'h0000_0104);
    tick();
    count_fetch(n_fetch);
    check("lat_cycles_108", 32'(n_fetch), 32'd4);
    check("lat_pc_108",     bus.instr_pc, 32'h0000_0108);
    tick();
    check("lat_retired_3", retired_count, 32'd3);
    check("lat_addr_10c",  bus.imem_addr, 32'h0000_010C);

    // ---- Backpressure with branch_taken toggling
    bus.instr_ready = 1'b0;
    lat_cfg = 1;
    wait_valid("bp_wait");
    check("bp_pc", bus.instr_pc, 32'h0000_010C);
    saved_instr = bus.instr;
    for (int i = 0; i < 5; i++) begin
      bus.branch_taken  = (i % 2 == 0);
      bus.branch_target = 32'h0000_0300 + 32'(i);
      tick();
      check("bp_instr_held", bus.instr,         saved_instr);
      check("bp_no_req",     32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0200;
    tick();
    check("br_addr",   bus.imem_addr,       32'h0000_0200);
    check("br_req",    32'(bus.imem_req),   32'd1);
    check("br_opcode", 32'(bus.opcode),     32'h13);
    check("br_retired", retired_count,      32'd4);

    // ---- PC wrap at the top of the address space
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    wait_valid("wrap_wait0");
    check("wrap_pc_200", bus.instr_pc, 32'h0000_0200);
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    wait_valid("wrap_wait1");
    check("wrap_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
    bus.instr_ready = 1'b1;
    tick();
    check("wrap_addr_zero", bus.imem_addr,  32'h0000_0000);
    check("wrap_retired",   retired_count,  32'd6);

    // ---- Retire counter wrap from a preloaded value
    force dut.r_retired_count = 32'hFFFF_FFFE;
    preload_val = 32'hFFFF_FFFE;
    preload_seq = preload_seq + 1;
    #1;
    release dut.r_retired_count;
    wait_valid("cnt_wait0");
    check("cnt_preload", retired_count, 32'hFFFF_FFFE);
    tick();
    check("cnt_max",  retired_count, 32'hFFFF_FFFF);
    check("cnt_addr", bus.imem_addr, 32'h0000_0004);
    wait_valid("cnt_wait1");
    tick();
    check("cnt_wrap", retired_count, 32'h0000_0000);

    // ---- Asynchronous reset in the middle of a memory wait
    bus.instr_ready = 1'b0;
    lat_cfg = 3;
    check("mid_pre_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr",   bus.imem_addr,        RESET_PC);
    check("mid_rst_instr",  bus.instr,            32'h0000_0013);
    check("mid_rst_pc",     bus.instr_pc,         RESET_PC);
    check("mid_rst_valid",  32'(bus.instr_valid), 32'd0);
    check("mid_rst_fault",  32'(fetch_fault),     32'd0);
    check("mid_rst_retire", retired_count,        32'd0);
    check("mid_rst_req",    32'(bus.imem_req),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_valid("mid_resume");
    check("mid_resume_pc",    bus.instr_pc, RESET_PC);
    check("mid_resume_instr", bus.instr,    32'h0050_0093);

    // ---- Randomised traffic: random latency, stray acks, random redirects
    rand_lat  = 1'b1;
    stray_ack = 1'b1;
    for (int i = 0; i < 800; i++) begin
      bus.instr_ready   = ($urandom_range(0, 2) != 0);
      bus.branch_taken  = ($urandom_range(0, 3) == 0);
      bus.branch_target = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;

    // ---- Misaligned redirect
    wait_valid("flt_wait");
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0202;
    tick();
    check("flt_fault", 32'(fetch_fault),     32'd1);
    check("flt_valid", 32'(bus.instr_valid), 32'd0);
    check("flt_instr", bus.instr,            32'h0000_0013);
    for (int i = 0; i < 20; i++) begin
      bus.instr_ready   = ($urandom_range(0, 1) == 1);
      bus.branch_taken  = ($urandom_range(0, 1) == 1);
      bus.branch_target = $urandom;
      tick();
      check("flt_no_req", 32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("flt_rst_fault", 32'(fetch_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("flt_resume_req",  32'(bus.imem_req), 32'd1);
    check("flt_resume_addr", bus.imem_addr,     RESET_PC);
    wait_valid("flt_resume_wait");
    check("flt_resume_pc", bus.instr_pc, RESET_PC);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage feeding the two-phase control/decode unit. Holds the program counter, issues one request at a time to instruction memory, and captures the returned word in an instruction register. It presents the word, its PC and its opcode field to the decode stage under a valid/ready handshake, then advances the PC sequentially or to a branch target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `NOP_INSTR`, default 32'h0000_0013: instruction register contents whenever no valid instruction is held (`addi x0,x0,0`).
- Reset is asynchronous and active-low, and the block uses one clock.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `imem_req` output 1: fetch request, held high until acknowledged.
- `imem_addr` output 32: fetch address, equal to the PC and stable while `imem_req` is high.
- `imem_ack` input 1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata` input 32: fetched instruction word.
- `instr_valid` output 1: the instruction register holds an unconsumed instruction.
- `instr_ready` input 1: decode accepts the instruction; the same signal as the decoder's PC-write phase.
- `instr` output 32: instruction register.
- `instr_pc` output 32: PC of `instr`.
- `opcode` output 7: `instr[6:0]`, wired directly to the control unit.
- `branch_taken` input 1: next PC is `branch_target`; sampled only on a handshake.
- `branch_target` input 32: redirect address.
- `fetch_fault` output 1: sticky flag for a misaligned branch target.
- `retired_count` output 32: count of completed handshakes.

## Operation
The block is a three-state FSM: FETCH, HOLD and FAULT.

**FETCH**
- `imem_req`=1 and `imem_addr`=PC.
- When `imem_ack`=1: `instr`←`imem_rdata`, `instr_pc`←PC, move to HOLD.
- When `imem_ack`=0: stay in FETCH, keeping address and request stable.

**HOLD**
- `instr_valid`=1 and `imem_req`=0.
- Handshake is `instr_valid & instr_ready`. On a handshake:
  - `retired_count` increments by 1, wrapping modulo 2^32.
  - If `branch_taken`=0: PC←PC+4, wrapping modulo 2^32. Move to FETCH.
  - If `branch_taken`=1 and `branch_target[1:0]`==0: PC←`branch_target`. Move to FETCH.
  - If `branch_taken`=1 and `branch_target[1:0]`≠0: PC is unchanged, `fetch_fault`←1, move to FAULT.
- Without a handshake, `instr` and `instr_pc` are held and `branch_taken` is ignored.

**FAULT**
- `imem_req`=0, `instr_valid`=0, `instr`=NOP_INSTR.
- The block stays in FAULT until reset.

**General rules**
- `instr` is loaded with NOP_INSTR on every HOLD→FETCH or HOLD→FAULT transition, so `opcode` never carries a stale decode.
- `imem_ack` is ignored outside FETCH.
- `imem_rdata` is captured only in a cycle where both FETCH and `imem_ack` hold.

## Timing
- Reset values:
  - state=FETCH, PC=RESET_PC, `instr`=NOP_INSTR, `instr_pc`=RESET_PC.
  - `instr_valid`=0, `fetch_fault`=0, `retired_count`=0.
  - `imem_req`=1 immediately after `rst_n` deasserts.
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state only; there is no combinational path from any input.
- Zero-wait memory (ack in the request cycle): `instr_valid` rises the next cycle.
- N wait cycles add N cycles of latency.
- Best-case throughput is one instruction per 2 cycles (FETCH, HOLD), matching the decoder's READ/EXECUTE alternation.
- The first fetch after a handshake is issued in the cycle after the handshake, to the updated PC.
- Asserting `rst_n` mid-FETCH or mid-HOLD aborts the transaction; a late `imem_ack` arriving after reset lands in the new FETCH and is accepted.
- The memory must not ack a request that was aborted by reset.

## Structure
- The shared package `rv_pkg` holds:
  - the FSM state enum (FETCH/HOLD/FAULT);
  - the constants `NOP_INSTR` and the instruction length 4;
  - the opcode field slice constants, also used by the control unit.
- One natural sub-module, `pc_next`: combinational next-PC selection plus alignment check, with inputs PC, `branch_taken`, `branch_target` and outputs next_pc, misaligned.
- The FSM, instruction register and counter stay in `ifetch_unit`.

## Test plan
- Reset with RESET_PC=0x100 and zero-wait memory returning 0x00500093:
  - `imem_addr`=0x100 in the first cycle;
  - `instr_valid`=1, `opcode`=7'b0010011, `instr_pc`=0x100 the next cycle.
- 3-cycle memory latency with `instr_ready` held high:
  - `imem_addr` is stable for 4 cycles;
  - successive `instr_pc` values are 0x100, 0x104, 0x108;
  - `retired_count` = 3 after three handshakes.
- Backpressure, with `instr_ready`=0 for 5 cycles in HOLD and `branch_taken` toggling:
  - `instr` is unchanged and no `imem_req` is issued;
  - the handshake with `branch_taken`=1 and `branch_target`=0x200 gives the next `imem_addr`=0x200.
- Misaligned redirect (handshake with `branch_taken`=1, `branch_target`=0x202):
  - `fetch_fault`=1 and `instr_valid`=0;
  - `imem_req` stays 0 for 20 cycles;
  - after reset, fetch resumes at RESET_PC with `fetch_fault`=0.
- Wrap and reset boundaries:
  - PC=0xFFFF_FFFC with a sequential handshake gives next `imem_addr`=0x0;
  - `retired_count` preloaded near 0xFFFF_FFFF wraps to 0;
  - `rst_n` pulsed mid-wait restores all reset values asynchronously.
